// File: rtl/microsequencer_pkg.sv
// microsequencer_pkg
// Shared definitions for the microsequencer and anything that builds or
// decodes microcommand words:
//   - bit indices inside the microcommand word (UC_*)
//   - run/wait/halt state encoding
//   - INT opcode prefix and a helper that builds an injected INT word
package microsequencer_pkg;

   // Microcommand bit indices. The immediate-control bits already existed;
   // the sequencing bits sit at the top of the word, clear of them.
   localparam int UC_IMM_SHIFT           = 0;
   localparam int UC_IMM_EXTEND_NEGATIVE = 1;
   localparam int UC_MEM_WAIT            = 25;
   localparam int UC_LOAD_IR             = 26;
   localparam int UC_END                 = 27;

   // Top three bits of the decoder's INT encoding.
   localparam logic [2:0] INT_OPCODE_PREFIX = 3'b100;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAITING = 2'd1,
      ST_HALTED  = 2'd2
   } seqState_t;

   // The instruction word that is injected in place of a memory fetch when
   // an interrupt is taken.
   function automatic logic [15:0] intInstruction(input logic [8:0] vec);
      return {INT_OPCODE_PREFIX, 4'b0000, vec};
   endfunction

endpackage

// File: rtl/microsequencer.sv
// microsequencer
// Sequential control stage in front of the instruction decoder. Holds the
// instruction register, microcode phase, fetch flag, interrupt enable and
// the run/wait/halt state, and advances them every cycle from the current
// microcommand word. Interrupts are injected as INT instructions at
// instruction boundaries, without a memory fetch.
//
// Ports:
//   clk, rst       single clock; synchronous active-high reset
//   ucommand       current microcommand word from the microcode ROM
//   instr_in       instruction word from memory
//   mem_ready      memory access completes this cycle
//   irq_req        level interrupt request
//   irq_vec        interrupt vector number
//   halt, _wait    decoder: current instruction halts / waits
//   ei, di, rti    decoder: enable / disable interrupts, return from interrupt
//   phase          microcode phase to the decoder
//   fetch          fetch sequence active
//   instruction    instruction register
//   exc_triggered  current instruction is an injected interrupt
//   ie             interrupt enable
//   irq_ack        one-cycle pulse when an interrupt is taken
//   halted         HALTED state indicator
//   waiting        WAITING state indicator
//   ucode_err      sticky: a microprogram ran past phase 7 without UC_END
module microsequencer
   import microsequencer_pkg::*;
#(
   parameter int UC_W = 28
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [UC_W-1:0] ucommand,
   input  logic [15:0]     instr_in,
   input  logic            mem_ready,
   input  logic            irq_req,
   input  logic [8:0]      irq_vec,
   input  logic            halt,
   input  logic            _wait,
   input  logic            ei,
   input  logic            di,
   input  logic            rti,
   output logic [2:0]      phase,
   output logic            fetch,
   output logic [15:0]     instruction,
   output logic            exc_triggered,
   output logic            ie,
   output logic            irq_ack,
   output logic            halted,
   output logic            waiting,
   output logic            ucode_err
);

   seqState_t   r_state;
   logic [2:0]  r_phase;
   logic        r_fetch;
   logic [15:0] r_instruction;
   logic        r_excTriggered;
   logic        r_ie;
   logic        r_irqAck;
   logic        r_ucodeErr;

   seqState_t   w_state;
   logic [2:0]  w_phase;
   logic        w_fetch;
   logic [15:0] w_instruction;
   logic        w_excTriggered;
   logic        w_ie;
   logic        w_irqAck;
   logic        w_ucodeErr;

   logic        w_ucEnd;
   logic        w_ucLoadIr;
   logic        w_ucMemWait;
   logic        w_stall;
   logic        w_phaseOverrun;
   logic        w_seqEnd;
   logic        w_unusedUcBits;

   assign w_ucEnd     = ucommand[UC_END];
   assign w_ucLoadIr  = ucommand[UC_LOAD_IR];
   assign w_ucMemWait = ucommand[UC_MEM_WAIT];

   // The remaining microcommand bits belong to the decoder's datapath.
   assign w_unusedUcBits = ^ucommand;

   assign w_stall        = w_ucMemWait && !mem_ready;
   assign w_phaseOverrun = (r_phase == 3'd7) && !w_ucEnd;
   assign w_seqEnd       = w_ucEnd || w_phaseOverrun;

   // State register: every piece of sequencing state lives here, so all
   // outputs are registered and change only on clock edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_phase        <= 3'd0;
         r_fetch        <= 1'b1;
         r_instruction  <= 16'h0000;
         r_excTriggered <= 1'b0;
         r_ie           <= 1'b0;
         r_irqAck       <= 1'b0;
         r_ucodeErr     <= 1'b0;
      end else begin
         r_state        <= w_state;
         r_phase        <= w_phase;
         r_fetch        <= w_fetch;
         r_instruction  <= w_instruction;
         r_excTriggered <= w_excTriggered;
         r_ie           <= w_ie;
         r_irqAck       <= w_irqAck;
         r_ucodeErr     <= w_ucodeErr;
      end
   end

   // Next-state logic. Everything holds by default and irq_ack falls back to
   // zero, so a memory stall or HALTED simply takes the defaults. At an
   // instruction boundary the interrupt decision uses r_ie (the enable as it
   // stood before this instruction's ei/di/rti), so an ei never opens the
   // window for an interrupt at its own boundary. Taking an interrupt
   // overrides the ie update and clears it.
   always_comb begin
      w_state        = r_state;
      w_phase        = r_phase;
      w_fetch        = r_fetch;
      w_instruction  = r_instruction;
      w_excTriggered = r_excTriggered;
      w_ie           = r_ie;
      w_irqAck       = 1'b0;
      w_ucodeErr     = r_ucodeErr;

      unique case (r_state)
         ST_RUN: begin
            if (!w_stall) begin
               if (r_fetch && w_ucLoadIr) begin
                  w_instruction = instr_in;
               end
               if (w_phaseOverrun) begin
                  w_ucodeErr = 1'b1;
               end

               if (!w_seqEnd) begin
                  w_phase = r_phase + 3'd1;
               end else if (r_fetch) begin
                  w_fetch = 1'b0;
                  w_phase = 3'd0;
               end else begin
                  w_excTriggered = 1'b0;
                  if (ei || rti) begin
                     w_ie = 1'b1;
                  end else if (di) begin
                     w_ie = 1'b0;
                  end

                  if (halt) begin
                     w_state = ST_HALTED;
                  end else if (_wait) begin
                     w_state = ST_WAITING;
                  end else if (r_ie && irq_req) begin
                     w_instruction  = intInstruction(irq_vec);
                     w_fetch        = 1'b0;
                     w_phase        = 3'd0;
                     w_excTriggered = 1'b1;
                     w_ie           = 1'b0;
                     w_irqAck       = 1'b1;
                  end else begin
                     w_fetch = 1'b1;
                     w_phase = 3'd0;
                  end
               end
            end
         end

         ST_WAITING: begin
            if (irq_req) begin
               w_state = ST_RUN;
               if (r_ie) begin
                  w_instruction  = intInstruction(irq_vec);
                  w_fetch        = 1'b0;
                  w_phase        = 3'd0;
                  w_excTriggered = 1'b1;
                  w_ie           = 1'b0;
                  w_irqAck       = 1'b1;
               end else begin
                  w_fetch = 1'b1;
                  w_phase = 3'd0;
               end
            end
         end

         ST_HALTED: begin
         end

         default: begin
            w_state = ST_RUN;
         end
      endcase
   end

   // Output decode straight from the registers.
   always_comb begin
      phase         = r_phase;
      fetch         = r_fetch;
      instruction   = r_instruction;
      exc_triggered = r_excTriggered;
      ie            = r_ie;
      irq_ack       = r_irqAck;
      halted        = (r_state == ST_HALTED);
      waiting       = (r_state == ST_WAITING);
      ucode_err     = r_ucodeErr;
   end

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer
// Directed bench for the microsequencer. A behavioural model tracks what a
// sequencer obeying the instruction-cycle rules must show, and is compared
// against the DUT every cycle; literal expectations along the way pin the
// model itself.
module tb_microsequencer;
   import microsequencer_pkg::*;

   localparam int UC_W = 28;

   localparam logic [UC_W-1:0] UC_NONE = '0;
   localparam logic [UC_W-1:0] UC_E    = UC_W'(1) << UC_END;
   localparam logic [UC_W-1:0] UC_L    = UC_W'(1) << UC_LOAD_IR;
   localparam logic [UC_W-1:0] UC_M    = UC_W'(1) << UC_MEM_WAIT;
   localparam logic [UC_W-1:0] UC_LE   = UC_L | UC_E;

   logic            clk;
   logic            rst;
   logic [UC_W-1:0] ucommand;
   logic [15:0]     instr_in;
   logic            mem_ready;
   logic            irq_req;
   logic [8:0]      irq_vec;
   logic            halt;
   logic            waitIn;
   logic            ei;
   logic            di;
   logic            rti;
   logic [2:0]      phase;
   logic            fetch;
   logic [15:0]     instruction;
   logic            exc_triggered;
   logic            ie;
   logic            irq_ack;
   logic            halted;
   logic            waiting;
   logic            ucode_err;

   int nCompared;
   int nMismatched;
   bit compareOn;

   // Model state
   int          mPhase;
   bit          mFetch;
   logic [15:0] mInstr;
   bit          mExc;
   bit          mIe;
   bit          mAck;
   bit          mErr;
   int          mMode;

   microsequencer #(.UC_W(UC_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .ucommand     (ucommand),
      .instr_in     (instr_in),
      .mem_ready    (mem_ready),
      .irq_req      (irq_req),
      .irq_vec      (irq_vec),
      .halt         (halt),
      ._wait        (waitIn),
      .ei           (ei),
      .di           (di),
      .rti          (rti),
      .phase        (phase),
      .fetch        (fetch),
      .instruction  (instruction),
      .exc_triggered(exc_triggered),
      .ie           (ie),
      .irq_ack      (irq_ack),
      .halted       (halted),
      .waiting      (waiting),
      .ucode_err    (ucode_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelTakeInterrupt(input logic [8:0] vec);
      mInstr = 16'h8000 | {7'd0, vec};
      mFetch = 1'b0;
      mPhase = 0;
      mExc   = 1'b1;
      mIe    = 1'b0;
      mAck   = 1'b1;
   endtask

   // One instruction-cycle step of the model. Mode: 0 run, 1 waiting, 2 halted.
   task automatic modelStep;
      bit finished;
      bit oldIe;
      mAck = 1'b0;
      if (mMode == 1) begin
         if (irq_req) begin
            if (mIe) modelTakeInterrupt(irq_vec);
            else begin
               mFetch = 1'b1;
               mPhase = 0;
            end
            mMode = 0;
         end
      end else if (mMode == 0 && !(ucommand[UC_MEM_WAIT] && !mem_ready)) begin
         if (mFetch && ucommand[UC_LOAD_IR]) mInstr = instr_in;
         finished = ucommand[UC_END] || (mPhase == 7);
         if (!ucommand[UC_END] && mPhase == 7) mErr = 1'b1;
         if (!finished) mPhase = mPhase + 1;
         else if (mFetch) begin
            mFetch = 1'b0;
            mPhase = 0;
         end else begin
            oldIe = mIe;
            mExc  = 1'b0;
            if (ei || rti) mIe = 1'b1;
            else if (di) mIe = 1'b0;
            if (halt) mMode = 2;
            else if (waitIn) mMode = 1;
            else if (oldIe && irq_req) modelTakeInterrupt(irq_vec);
            else begin
               mFetch = 1'b1;
               mPhase = 0;
            end
         end
      end
   endtask

   // Model advances on the same edge as the DUT, from the same inputs.
   always @(posedge clk) begin
      if (rst) begin
         mPhase = 0;
         mFetch = 1'b1;
         mInstr = 16'h0000;
         mExc   = 1'b0;
         mIe    = 1'b0;
         mAck   = 1'b0;
         mErr   = 1'b0;
         mMode  = 0;
      end else begin
         modelStep();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (compareOn) begin
         checkOutput("phase", 16'(phase), 16'(mPhase));
         checkOutput("fetch", 16'(fetch), 16'(mFetch));
         checkOutput("instruction", instruction, mInstr);
         checkOutput("exc_triggered", 16'(exc_triggered), 16'(mExc));
         checkOutput("ie", 16'(ie), 16'(mIe));
         checkOutput("irq_ack", 16'(irq_ack), 16'(mAck));
         checkOutput("halted", 16'(halted), 16'(mMode == 2));
         checkOutput("waiting", 16'(waiting), 16'(mMode == 1));
         checkOutput("ucode_err", 16'(ucode_err), 16'(mErr));
      end
   end

   // Drive one cycle of inputs, let the edge pass, and settle just after it.
   task automatic applyStimulus(input logic [UC_W-1:0] uc, input logic [15:0] instr,
                                input logic memRdy, input logic irq, input logic [8:0] vec,
                                input logic [4:0] dec);
      ucommand  = uc;
      instr_in  = instr;
      mem_ready = memRdy;
      irq_req   = irq;
      irq_vec   = vec;
      {halt, waitIn, ei, di, rti} = dec;
      @(posedge clk);
      #1;
   endtask

   localparam logic [4:0] D_NONE = 5'b00000;
   localparam logic [4:0] D_HALT = 5'b10000;
   localparam logic [4:0] D_WAIT = 5'b01000;
   localparam logic [4:0] D_EI   = 5'b00100;

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      compareOn   = 1'b0;
      rst         = 1'b1;
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      compareOn = 1'b1;
      checkOutput("reset fetch", 16'(fetch), 16'd1);
      checkOutput("reset phase", 16'(phase), 16'd0);
      checkOutput("reset ie", 16'(ie), 16'd0);
      checkOutput("reset instruction", instruction, 16'h0000);
      rst = 1'b0;

      // Fetch and a four-cycle execute
      applyStimulus(UC_LE, 16'h1234, 1'b1, 1'b0, 9'h0, D_NONE);
      checkOutput("load ir", instruction, 16'h1234);
      checkOutput("load fetch", 16'(fetch), 16'd0);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
         checkOutput("exec phase", 16'(phase), 16'(i));
      end
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      checkOutput("end fetch", 16'(fetch), 16'd1);
      checkOutput("end phase", 16'(phase), 16'd0);

      // Runaway microprogram
      applyStimulus(UC_LE, 16'h0001, 1'b1, 1'b0, 9'h0, D_NONE);
      for (int i = 0; i < 8; i++) applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      checkOutput("overrun err", 16'(ucode_err), 16'd1);
      checkOutput("overrun fetch", 16'(fetch), 16'd1);

      // Memory stall
      for (int i = 0; i < 4; i++) applyStimulus(UC_M | UC_LE, 16'hBEEF, 1'b0, 1'b0, 9'h0, D_NONE);
      checkOutput("stall ir", instruction, 16'h0001);
      checkOutput("stall fetch", 16'(fetch), 16'd1);
      applyStimulus(UC_M | UC_LE, 16'hABCD, 1'b1, 1'b0, 9'h0, D_NONE);
      checkOutput("stall release ir", instruction, 16'hABCD);

      // Enable interrupts, then take one at the next boundary
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_EI);
      checkOutput("ei ie", 16'(ie), 16'd1);
      applyStimulus(UC_LE, 16'h2222, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b1, 9'h005, D_NONE);
      checkOutput("int ir", instruction, 16'h8005);
      checkOutput("int exc", 16'(exc_triggered), 16'd1);
      checkOutput("int ack", 16'(irq_ack), 16'd1);
      checkOutput("int ie", 16'(ie), 16'd0);
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      checkOutput("ack pulse", 16'(irq_ack), 16'd0);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      checkOutput("exc clear", 16'(exc_triggered), 16'd0);

      // ei does not open the window at its own boundary
      applyStimulus(UC_LE, 16'h3333, 1'b1, 1'b1, 9'h007, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b1, 9'h007, D_EI);
      checkOutput("ei boundary ack", 16'(irq_ack), 16'd0);
      checkOutput("ei boundary fetch", 16'(fetch), 16'd1);
      applyStimulus(UC_LE, 16'h4444, 1'b1, 1'b1, 9'h007, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b1, 9'h007, D_NONE);
      checkOutput("late int ir", instruction, 16'h8007);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);

      // Halt beats an interrupt and sticks until reset
      applyStimulus(UC_LE, 16'h5555, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_EI);
      applyStimulus(UC_LE, 16'h6666, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b1, 9'h003, D_HALT);
      checkOutput("halt halted", 16'(halted), 16'd1);
      checkOutput("halt ack", 16'(irq_ack), 16'd0);
      for (int i = 0; i < 3; i++) applyStimulus(UC_LE, 16'h9999, 1'b1, 1'b1, 9'h003, D_NONE);
      checkOutput("halt hold ir", instruction, 16'h6666);
      checkOutput("halt hold", 16'(halted), 16'd1);
      rst = 1'b1;
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      rst = 1'b0;
      checkOutput("halt reset", 16'(halted), 16'd0);

      // Wait, then wake without interrupts enabled
      applyStimulus(UC_LE, 16'h7777, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_WAIT);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
         checkOutput("waiting", 16'(waiting), 16'd1);
      end
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b1, 9'h0, D_NONE);
      checkOutput("wake waiting", 16'(waiting), 16'd0);
      checkOutput("wake fetch", 16'(fetch), 16'd1);
      checkOutput("wake ack", 16'(irq_ack), 16'd0);

      // Wait, then wake into an interrupt
      applyStimulus(UC_LE, 16'h1111, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_EI);
      applyStimulus(UC_LE, 16'h1112, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_E, 16'h0, 1'b1, 1'b0, 9'h0, D_WAIT);
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b1, 9'h1FF, D_NONE);
      checkOutput("wait int ir", instruction, 16'h81FF);
      checkOutput("wait int ack", 16'(irq_ack), 16'd1);

      // Reset in the middle of a stall
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);
      applyStimulus(UC_M, 16'h0, 1'b0, 1'b0, 9'h0, D_NONE);
      rst = 1'b1;
      applyStimulus(UC_M, 16'h0, 1'b0, 1'b0, 9'h0, D_NONE);
      rst = 1'b0;
      checkOutput("stall reset phase", 16'(phase), 16'd0);
      checkOutput("stall reset fetch", 16'(fetch), 16'd1);
      applyStimulus(UC_NONE, 16'h0, 1'b1, 1'b0, 9'h0, D_NONE);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
